// File: rtl/cmp_serial_ctrl.sv
// Serial magnitude comparator sequencer: walks a WIDTH-bit compare through one
// shared external comparator3 slice, LSB slice first, with start/busy/done handshake.
module cmp_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int SLICE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             l_in,
  input  logic             e_in,
  input  logic             g_in,
  output logic [SLICE-1:0] sl_p,
  output logic [SLICE-1:0] sl_q,
  output logic             sl_l,
  output logic             sl_e,
  output logic             sl_g,
  input  logic             sl_lt,
  input  logic             sl_et,
  input  logic             sl_gt,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             et,
  output logic             gt,
  output logic             err
);

  localparam int N     = (WIDTH + SLICE - 1) / SLICE;
  localparam int PW    = N * SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Flag vectors are ordered {l, e, g} throughout.
  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [PW-1:0]    b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       flags_q, flags_d;
  logic [2:0]       res_q, res_d;
  logic             err_q, err_d;
  logic [2:0]       slice_res;
  logic [2:0]       start_flags;

  assign slice_res = {sl_lt, sl_et, sl_gt};

  // g beats l; e is the fallback so an all-zero cascade still means "equal so far".
  assign start_flags = g_in ? 3'b001 :
                       l_in ? 3'b100 : 3'b010;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    flags_d = flags_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = PW'(a);
          b_d     = PW'(b);
          idx_d   = '0;
          err_d   = 1'b0;
          flags_d = start_flags;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        flags_d = slice_res;
        idx_d   = idx_q + 1'b1;
        if (!$onehot(slice_res)) err_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          res_d   = slice_res;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      flags_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      flags_q <= flags_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  // The shared slice sees all-zero inputs whenever this sequencer is not using it.
  always_comb begin
    sl_p = '0;
    sl_q = '0;
    {sl_l, sl_e, sl_g} = 3'b000;
    if (busy) begin
      sl_p = a_q[idx_q*SLICE +: SLICE];
      sl_q = b_q[idx_q*SLICE +: SLICE];
      {sl_l, sl_e, sl_g} = flags_q;
    end
  end

  assign {lt, et, gt} = res_q;
  assign err          = err_q;

endmodule

// File: tb/tb_cmp_serial_ctrl.sv
// Directed bench for cmp_serial_ctrl (WIDTH=8, three slices) with a behavioral
// comparator3 model and a hook to corrupt the slice result.
module tb_cmp_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       l_in, e_in, g_in;
  logic [2:0] sl_p, sl_q;
  logic       sl_l, sl_e, sl_g;
  logic       sl_lt, sl_et, sl_gt;
  logic       busy, done, lt, et, gt, err;
  logic       inject;

  int n_cmp = 0;
  int n_bad = 0;

  cmp_serial_ctrl #(.WIDTH(8), .SLICE(3)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .l_in(l_in), .e_in(e_in), .g_in(g_in),
    .sl_p(sl_p), .sl_q(sl_q), .sl_l(sl_l), .sl_e(sl_e), .sl_g(sl_g),
    .sl_lt(sl_lt), .sl_et(sl_et), .sl_gt(sl_gt),
    .busy(busy), .done(done), .lt(lt), .et(et), .gt(gt), .err(err)
  );

  always #5 clk = ~clk;

  // comparator3 model: magnitude decides, equality passes the cascade through
  always_comb begin
    if (sl_p > sl_q)      {sl_lt, sl_et, sl_gt} = 3'b001;
    else if (sl_p < sl_q) {sl_lt, sl_et, sl_gt} = 3'b100;
    else                  {sl_lt, sl_et, sl_gt} = {sl_l, sl_e, sl_g};
    if (inject)           {sl_lt, sl_et, sl_gt} = 3'b101;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] pa, input logic [7:0] pb,
                          input logic l, input logic e, input logic g);
    @(negedge clk);
    a = pa; b = pb; l_in = l; e_in = e; g_in = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0; l_in = 1'b0; e_in = 1'b0; g_in = 1'b0;
  endtask

  // Called in the first RUN cycle; ends in the DONE cycle after checking the result.
  task automatic finish_op(input string tag, input logic [2:0] exp_res, input logic exp_err);
    check({tag, "_busy0"}, {7'd0, busy}, 8'd1);
    repeat (2) begin
      @(negedge clk);
      check({tag, "_busy"}, {6'd0, busy, done}, 8'b10);
    end
    @(negedge clk);
    check({tag, "_done"}, {6'd0, busy, done}, 8'b01);
    check({tag, "_res"},  {5'd0, lt, et, gt}, {5'd0, exp_res});
    check({tag, "_err"},  {7'd0, err}, {7'd0, exp_err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    l_in = 1'b0; e_in = 1'b0; g_in = 1'b0; inject = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {6'd0, busy, done}, 8'd0);
    check("reset_res", {4'd0, lt, et, gt, err}, 8'd0);
    check("reset_sl",  {sl_p, sl_q, sl_l, sl_e}, 8'd0);
    rst = 1'b0;

    // equal operands, slice drive in the first RUN cycle
    start_op(8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0);
    check("eq_slice0", {sl_p, sl_q, sl_l, sl_e}, {3'd5, 3'd5, 2'b01});
    finish_op("eq", 3'b010, 1'b0);
    check("eq_sl_done", {sl_p, sl_q, sl_l, sl_e}, 8'd0);
    @(negedge clk);
    check("eq_pulse", {6'd0, busy, done}, 8'd0);
    check("eq_held",  {5'd0, lt, et, gt}, 8'b010);

    // top slice overrides lower-slice lt
    start_op(8'h80, 8'h7F, 1'b0, 1'b1, 1'b0);
    finish_op("gt_top", 3'b001, 1'b0);
    start_op(8'h07, 8'h38, 1'b0, 1'b1, 1'b0);
    finish_op("lt_mid", 3'b100, 1'b0);

    // equal operands resolve to the normalized cascade input
    start_op(8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
    finish_op("casc_l", 3'b100, 1'b0);
    start_op(8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1);
    finish_op("casc_g", 3'b001, 1'b0);
    start_op(8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);
    finish_op("casc_0", 3'b010, 1'b0);

    // start while busy is ignored; start in DONE is accepted
    start_op(8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
    a = 8'hFF; b = 8'h00; g_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; g_in = 1'b0;
    check("ign_busy", {7'd0, busy}, 8'd1);
    check("ign_slice1", {2'd0, sl_p, sl_q}, {2'd0, 3'd2, 3'd4});
    @(negedge clk);
    check("ign_busy2", {6'd0, busy, done}, 8'b10);
    @(negedge clk);
    check("ign_done", {6'd0, busy, done}, 8'b01);
    check("ign_res", {5'd0, lt, et, gt}, 8'b100);
    a = 8'hFF; b = 8'h00; e_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; e_in = 1'b0;
    check("b2b_busy", {6'd0, busy, done}, 8'b10);
    check("b2b_held", {5'd0, lt, et, gt}, 8'b100);
    finish_op("b2b", 3'b001, 1'b0);

    // reset mid-RUN aborts with no done pulse
    start_op(8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ctl", {6'd0, busy, done}, 8'd0);
    check("abort_res", {4'd0, lt, et, gt, err}, 8'd0);
    check("abort_sl",  {sl_p, sl_q, sl_l, sl_e}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_nodone", {6'd0, busy, done}, 8'd0);
    start_op(8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0);
    finish_op("post_rst", 3'b010, 1'b0);

    // corrupted slice 1 result sets a sticky err and loads the flags as received
    start_op(8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    check("err_run", {7'd0, err}, 8'd1);
    @(negedge clk);
    check("err_done", {6'd0, busy, done}, 8'b01);
    check("err_res", {4'd0, lt, et, gt, err}, 8'b1011);
    @(negedge clk);
    check("err_held", {7'd0, err}, 8'd1);
    start_op(8'h42, 8'h42, 1'b0, 1'b1, 1'b0);
    check("err_clear", {7'd0, err}, 8'd0);
    finish_op("clean", 3'b010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_serial_ctrl.md
Name: cmp_serial_ctrl

Overview:
Sequencer that performs a WIDTH-bit magnitude compare by time-multiplexing one external comparator3 slice (3-bit compare with l/e/g cascade inputs), LSB slice first.
It replaces the three-slice combinational chain where area matters, and adds a start/busy/done handshake, result registers and a slice-sanity error flag.
It sits between requesting logic and a single shared comparator3 instance.

Parameters:
WIDTH, 8, operand width; operands are zero-extended to N*3 bits, where N = ceil(WIDTH/3).
SLICE, 3, slice width; fixed at 3 to match comparator3 and not overridable in practice.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; one clock; reset is synchronous and active-high.
start  input  1  request pulse; sampled only when busy=0.
a  input  WIDTH  operand p, captured on an accepted start.
b  input  WIDTH  operand q, captured on an accepted start.
l_in, e_in, g_in  input  1 each  initial cascade flags, captured on an accepted start.
sl_p  output  3  slice operand p to the external comparator3.
sl_q  output  3  slice operand q to the external comparator3.
sl_l, sl_e, sl_g  output  1 each  cascade flags to the slice.
sl_lt, sl_et, sl_gt  input  1 each  combinational slice result.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when the result becomes valid.
lt, et, gt  output  1 each  registered compare result; held until the next completion.
err  output  1  slice returned a non-one-hot result during the last operation.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, lt=et=gt=0, err=0, sl_*=0, idx=0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 -> RUN:
  - capture a and b (zero-extended) into operand registers, set idx=0;
  - clear err;
  - capture and normalize cascade flags into flag registers: g_in wins, else l_in, else e (e_in or no flag set -> e=1).
- IDLE or DONE with start=0: DONE -> IDLE; IDLE holds.
- RUN, every cycle:
  - drive sl_p = a_reg[3*idx+2:3*idx], sl_q = b_reg[same bits], and sl_l/sl_e/sl_g = flag registers;
  - on the clock edge, flags <= {sl_lt, sl_et, sl_gt} and idx <= idx+1;
  - if {sl_lt, sl_et, sl_gt} is not exactly one-hot, set err (sticky for the operation) and still load the flags as received.
- RUN exit: after the cycle with idx = N-1 -> DONE. lt/et/gt load the final flags on that same edge.
- DONE: done=1 for exactly one cycle; busy=0.
- Outside RUN: sl_p, sl_q and sl_l/e/g drive 0.
- Latency: start accepted at edge 0; result and done visible after edge N (N=3 cycles for WIDTH=8). Back-to-back throughput is one op per N+1 cycles.
- start while busy=1 is ignored; operands are not re-sampled.
- start during DONE is accepted; done still pulses for the finished operation.
- lt/et/gt and err hold their values through IDLE and the next RUN, updating only at the next completion. err is cleared at start and is visible from then on.
- rst mid-RUN: abort with no done pulse; all outputs return to their reset values on the next edge.
- Width rule: bits above WIDTH in the top slice are 0, so the unused bits compare equal.

Test Plan:
- The bench uses a behavioral comparator3 model: slice p>q -> gt, p<q -> lt, p=q -> cascade pass-through.
- a=8'hA5, b=8'hA5, e_in=1, start -> busy for 3 cycles; done at cycle 3; et=1, lt=gt=0, err=0.
- a=8'h80, b=8'h7F, e_in=1 -> gt=1 (decided in the top slice, overriding the lower-slice lt); a=8'h07, b=8'h38 -> lt=1.
- a=b=8'h3C with l_in=1, then again with g_in=1, then with all cascade inputs 0 -> lt=1, then gt=1, then et=1 respectively.
- Pulse start again in cycle 1 of RUN with different operands -> ignored; result reflects the first operands; start in the DONE cycle is accepted and busy rises next cycle.
- Assert rst in cycle 2 of RUN -> no done; the next edge gives lt=et=gt=0, busy=0; a fresh start then completes normally.
- Model forces sl_lt=sl_gt=1 in slice 1 -> err=1 at done and held; the next clean operation clears err at start.
